xcore_fetch_buf: RTL
====================

// Module: xcore_fetch_buf
// PURPOSE
//   Parametrised instruction-fetch unit: owns the fetch PC, issues pipelined requests on the RIB ROM
//   port and queues returned instructions with their PCs in a DEPTH-entry FIFO that feeds if_id.
//   Sits between ctrl (jump/redirect) and if_id; decouples ROM latency and ID stalls from the front end.
// PARAMETERS
//   ADDR_W    32     fetch address / PC width
//   DATA_W    32     instruction width; PC step = DATA_W/8
//   DEPTH     4      FIFO entries, power of 2, >=2; also the cap on FIFO entries + outstanding requests
//   RESET_PC  0      first fetch address after reset
// PORTS
//   clk           in   1       clock
//   rst           in   1       synchronous active-low reset (rst==0 resets on the rising clk edge)
//   jump_flag     in   1       redirect from ctrl; wins over every other event in the same cycle
//   jump_addr     in   ADDR_W  redirect target
//   rom_req       out  1       fetch request valid
//   rom_addr      out  ADDR_W  fetch address
//   rom_gnt       in   1       request accepted this cycle (rom_req && rom_gnt = issue)
//   rom_rvalid    in   1       in-order response valid, >=1 cycle after its grant
//   rom_rdata     in   DATA_W  response instruction
//   if_valid      out  1       FIFO head valid
//   if_pc         out  ADDR_W  head PC
//   if_inst       out  DATA_W  head instruction; 32'h00000013 (NOP), zero-extended, when !if_valid
//   id_ready      in   1       consumer accepts head (pop = if_valid && id_ready)
// BEHAVIOUR
//   Reset: state=S_BOOT, fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0; rom_req=0,
//     rom_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=NOP.
//   FSM: S_BOOT -> S_RUN after 1 cycle (no request in S_BOOT).
//     S_RUN: rom_req=1 iff fifo_cnt+outstanding < DEPTH; rom_addr=fetch_pc; on issue fetch_pc+=DATA_W/8,
//       wraps modulo 2^ADDR_W (0xFFFFFFFC -> 0x0).
//     jump_flag in any state: FIFO cleared, fetch_pc=jump_addr, pop ignored, same-cycle rom_rvalid dropped,
//       same-cycle grant counted as outstanding. drop = outstanding after that update. If drop==0 -> S_RUN,
//       else -> S_FLUSH.
//     S_FLUSH: rom_req=0; each rom_rvalid discarded, drop-=1; drop reaching 0 -> S_RUN next cycle.
//       jump in S_FLUSH retargets fetch_pc; drop unchanged (no new issues occurred).
//   Response push (S_RUN, no jump): {pc,inst} written at tail; PC per entry from a registered
//     response-PC counter that tracks issue order. Credit rule guarantees no overflow; push into full FIFO
//     is a design error (assert).
//   Outputs registered from FIFO head: response at cycle t -> if_valid at t+1. Best case
//     grant t, rvalid t+1, if_valid t+2. Simultaneous push+pop keeps fifo_cnt; pop on empty impossible.
//   Counters: fifo_cnt, outstanding, drop are clog2(DEPTH)+1 bits; never exceed DEPTH.
//   rst asserted mid-operation: all state returns to reset values next edge; late ROM responses after
//     reset are ignored (outstanding==0, S_BOOT/S_RUN drops rvalid when outstanding==0; assert warns).
// CONFIGURATION
//   FETCH_BUF_PERF_EN defined: adds ports perf_stall_cnt out 32 (cycles if_valid=0 in S_RUN) and
//     perf_flush_cnt out 32 (jumps taken); both reset to 0, saturate at 32'hFFFFFFFF.
//   Not defined: ports and counters absent; functional behaviour identical.
// TESTING
//   Reset, gnt=1, 1-cycle ROM, id_ready=1 -> rom_addr 0,4,8..; if_pc 0 first valid at cycle 3 after
//     rst release, then one instruction per cycle.
//   id_ready=0 with DEPTH=4 -> exactly 4 issues then rom_req=0; if_pc holds 0; release -> 0,4,8,C in order.
//   3 outstanding, jump_flag to 0x100 -> 3 responses discarded, S_FLUSH, then first if_pc=0x100.
//   jump_flag same cycle as pop and rvalid -> FIFO empty next cycle, if_valid=0, neither pop nor push.
//   fetch_pc=0xFFFFFFF8, 3 issues -> rom_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
//   rst low mid-burst with 2 outstanding -> next cycle if_valid=0, rom_req=0, rom_addr=RESET_PC;
//     with FETCH_BUF_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/xcore_fetch_buf_if.sv
// Fetch-buffer bus bundle: RIB ROM request/response port plus the if_id output stream.
// master = fetch buffer side, slave = ROM / decode side.
interface xcore_fetch_buf_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_gnt;
    logic              rom_rvalid;
    logic [DATA_W-1:0] rom_rdata;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_inst;
    logic              id_ready;

    modport master (
        output rom_req, rom_addr,
        input  rom_gnt, rom_rvalid, rom_rdata,
        output if_valid, if_pc, if_inst,
        input  id_ready
    );

    modport slave (
        input  rom_req, rom_addr,
        output rom_gnt, rom_rvalid, rom_rdata,
        input  if_valid, if_pc, if_inst,
        output id_ready
    );
endinterface

// File: rtl/xcore_fetch_buf.sv
// Instruction-fetch unit: owns the fetch PC, issues pipelined ROM requests and queues {pc,inst} for if_id.
// Optional FETCH_BUF_PERF_EN adds saturating stall/flush performance counters.
module xcore_fetch_buf #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] jump_addr,
    xcore_fetch_buf_if.master bus
`ifdef FETCH_BUF_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    localparam cnt_t              DEPTH_C = cnt_t'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(DATA_W / 8);
    localparam logic [DATA_W-1:0] NOP     = DATA_W'(32'h0000_0013);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    cnt_t              fifo_cnt, outstanding, drop;
    cnt_t              out_nxt;
    logic [CNT_W:0]    credit_used;
    logic              head_valid;
    logic              issue, rsp_live, do_push, do_pop;

    assign head_valid  = (fifo_cnt != '0);
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, outstanding};
    assign issue       = bus.rom_req && bus.rom_gnt;
    // Responses with nothing outstanding (e.g. stragglers from before a reset) are ignored.
    assign rsp_live    = bus.rom_rvalid && (outstanding != '0);
    assign do_push     = rsp_live && (state == S_RUN) && !jump_flag;
    assign do_pop      = head_valid && bus.id_ready && !jump_flag;
    assign out_nxt     = outstanding + cnt_t'(issue) - cnt_t'(rsp_live);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (jump_flag) begin
            state_nxt = (out_nxt == '0) ? S_RUN : S_FLUSH;
        end else begin
            case (state)
                S_BOOT:  state_nxt = S_RUN;
                S_RUN:   state_nxt = S_RUN;
                S_FLUSH: if (rsp_live && (drop == cnt_t'(1))) state_nxt = S_RUN;
                default: state_nxt = S_BOOT;
            endcase
        end
    end

    always_comb begin
        bus.rom_req  = 1'b0;
        bus.rom_addr = fetch_pc;
        bus.if_valid = head_valid;
        bus.if_pc    = '0;
        bus.if_inst  = NOP;
        if (state == S_RUN) begin
            bus.rom_req = (credit_used < {1'b0, DEPTH_C});
        end
        if (head_valid) begin
            bus.if_pc   = pc_mem[rd_ptr];
            bus.if_inst = inst_mem[rd_ptr];
        end
    end

    // On a redirect every in-flight response, including one granted this cycle, becomes a drop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= out_nxt;
            if (jump_flag) begin
                fetch_pc <= jump_addr;
                rsp_pc   <= jump_addr;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                drop     <= out_nxt;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if ((state == S_FLUSH) && rsp_live) begin
                    drop <= drop - cnt_t'(1);
                end
                if (do_push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_cnt <= fifo_cnt + cnt_t'(do_push) - cnt_t'(do_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            inst_mem[wr_ptr] <= bus.rom_rdata;
        end
    end

`ifdef FETCH_BUF_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if ((state == S_RUN) && !head_valid && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (jump_flag && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(do_push && (fifo_cnt == DEPTH_C)))
        else $error("fetch buffer push into full FIFO");

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst)
        !(bus.rom_rvalid && (outstanding == '0)))
        else $warning("ROM response with no request outstanding ignored");

endmodule
